// File: rtl/heapq_pkg.sv
// rtl/heapq_pkg.sv - op codes, FSM states and heap index helpers for the min-heap queue
package heapq_pkg;

  localparam logic [1:0] OP_NOP     = 2'd0;
  localparam logic [1:0] OP_PUSH    = 2'd1;
  localparam logic [1:0] OP_POP     = 2'd2;
  localparam logic [1:0] OP_REPLACE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SIFT_UP   = 2'd1,
    ST_SIFT_DOWN = 2'd2
  } heapq_state_e;

  function automatic int unsigned heap_parent(input int unsigned i);
    return (i == 0) ? 0 : (i - 1) / 2;
  endfunction

  function automatic int unsigned heap_left(input int unsigned i);
    return 2 * i + 1;
  endfunction

  function automatic int unsigned heap_right(input int unsigned i);
    return 2 * i + 2;
  endfunction

endpackage

// File: rtl/heapq_moore_if.sv
// rtl/heapq_moore_if.sv - command port and status bundle of the min-heap queue engine
interface heapq_moore_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              top_valid;
  logic [DATA_W-1:0] top_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              err;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, top_valid, top_data, count, full, empty, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, top_valid, top_data, count, full, empty, err
  );
endinterface

// File: rtl/heapq_min_child.sv
// rtl/heapq_min_child.sv - picks the smaller valid child of a heap node (left wins ties)
module heapq_min_child
  import heapq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4,
  parameter int IDX_W  = 3
) (
  input  logic [IDX_W-1:0]  i_cursor,
  input  logic [CNT_W-1:0]  i_count,
  input  logic [DATA_W-1:0] i_left_key,
  input  logic [DATA_W-1:0] i_right_key,
  output logic              o_has_child,
  output logic [IDX_W-1:0]  o_idx,
  output logic [DATA_W-1:0] o_key
);

  logic [31:0] w_left;
  logic [31:0] w_right;
  logic        w_left_vld;
  logic        w_right_vld;

  assign w_left      = heap_left(32'(i_cursor));
  assign w_right     = heap_right(32'(i_cursor));
  assign w_left_vld  = w_left < 32'(i_count);
  assign w_right_vld = w_right < 32'(i_count);

  // A valid right child implies a valid left child, so only the right needs a strict win
  always_comb begin
    o_has_child = w_left_vld;
    o_idx       = IDX_W'(w_left);
    o_key       = i_left_key;
    if (w_right_vld && (i_right_key < i_left_key)) begin
      o_idx = IDX_W'(w_right);
      o_key = i_right_key;
    end
  end

endmodule

// File: rtl/heapq_moore.sv
// rtl/heapq_moore.sv - min-priority queue with per-level sift FSM; REPLACE gated by HEAPQ_REPLACE_EN
module heapq_moore
  import heapq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic         system1000,
  input  logic         system1000_rstn,
  heapq_moore_if.slave q
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  heapq_state_e      r_state;
  heapq_state_e      w_state_nxt;
  logic [DATA_W-1:0] r_heap [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic [IDX_W-1:0]  r_cursor;
  logic              r_full;
  logic              r_empty;
  logic              r_err;

  logic              w_wr_a, w_wr_b;
  logic [IDX_W-1:0]  w_a_idx, w_b_idx;
  logic [DATA_W-1:0] w_a_data, w_b_data;
  logic              w_cnt_inc, w_cnt_dec;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_cur_ld;
  logic [IDX_W-1:0]  w_cur_nxt;
  logic              w_reject;

  logic              w_push_op, w_pop_op, w_repl_root, w_op3_rej;
  logic [IDX_W-1:0]  w_cnt_idx, w_last_idx, w_push_par, w_cur_par;
  logic              w_push_sift;
  logic [31:0]       w_left_i, w_right_i;
  logic [IDX_W-1:0]  w_lidx, w_ridx;
  logic              w_mc_has;
  logic [IDX_W-1:0]  w_mc_idx;
  logic [DATA_W-1:0] w_mc_key;
  logic              w_mc_deeper;

  // Op decode; REPLACE on an empty heap is folded into PUSH
`ifdef HEAPQ_REPLACE_EN
  assign w_push_op   = (q.cmd_op == OP_PUSH) || ((q.cmd_op == OP_REPLACE) && r_empty);
  assign w_repl_root = (q.cmd_op == OP_REPLACE) && !r_empty;
  assign w_op3_rej   = 1'b0;
`else
  assign w_push_op   = (q.cmd_op == OP_PUSH);
  assign w_repl_root = 1'b0;
  assign w_op3_rej   = (q.cmd_op == OP_REPLACE);
`endif
  assign w_pop_op = (q.cmd_op == OP_POP);

  assign w_cnt_idx  = r_full ? '0 : IDX_W'(r_count);
  assign w_last_idx = r_empty ? '0 : IDX_W'(32'(r_count) - 32'd1);
  assign w_push_par = IDX_W'(heap_parent(32'(w_cnt_idx)));
  assign w_cur_par  = IDX_W'(heap_parent(32'(r_cursor)));

  // Sift-up is only entered when the first comparison already calls for a swap
  assign w_push_sift = !r_empty && (r_heap[w_push_par] > q.cmd_data);

  assign w_left_i  = heap_left(32'(r_cursor));
  assign w_right_i = heap_right(32'(r_cursor));
  assign w_lidx    = (w_left_i < 32'(r_count)) ? IDX_W'(w_left_i) : '0;
  assign w_ridx    = (w_right_i < 32'(r_count)) ? IDX_W'(w_right_i) : '0;

  heapq_min_child #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .IDX_W  (IDX_W)
  ) u_min_child (
    .i_cursor    (r_cursor),
    .i_count     (r_count),
    .i_left_key  (r_heap[w_lidx]),
    .i_right_key (r_heap[w_ridx]),
    .o_has_child (w_mc_has),
    .o_idx       (w_mc_idx),
    .o_key       (w_mc_key)
  );

  assign w_mc_deeper = heap_left(32'(w_mc_idx)) < 32'(r_count);

  always_ff @(posedge system1000) begin
    if (!system1000_rstn) r_state <= ST_IDLE;
    else                  r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_a      = 1'b0;
    w_a_idx     = '0;
    w_a_data    = '0;
    w_wr_b      = 1'b0;
    w_b_idx     = '0;
    w_b_data    = '0;
    w_cnt_inc   = 1'b0;
    w_cnt_dec   = 1'b0;
    w_cur_ld    = 1'b0;
    w_cur_nxt   = '0;
    w_reject    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (q.cmd_valid) begin
          if (w_push_op) begin
            if (r_full) begin
              w_reject = 1'b1;
            end else begin
              w_wr_a    = 1'b1;
              w_a_idx   = w_cnt_idx;
              w_a_data  = q.cmd_data;
              w_cnt_inc = 1'b1;
              if (w_push_sift) begin
                w_cur_ld    = 1'b1;
                w_cur_nxt   = w_cnt_idx;
                w_state_nxt = ST_SIFT_UP;
              end
            end
          end else if (w_pop_op) begin
            if (r_empty) begin
              w_reject = 1'b1;
            end else begin
              w_wr_a    = 1'b1;
              w_a_idx   = '0;
              w_a_data  = r_heap[w_last_idx];
              w_cnt_dec = 1'b1;
              w_cur_ld  = 1'b1;
              if (r_count > CNT_W'(2)) w_state_nxt = ST_SIFT_DOWN;
            end
          end else if (w_repl_root) begin
            w_wr_a   = 1'b1;
            w_a_idx  = '0;
            w_a_data = q.cmd_data;
            w_cur_ld = 1'b1;
            if (r_count > CNT_W'(1)) w_state_nxt = ST_SIFT_DOWN;
          end else if (w_op3_rej) begin
            w_reject = 1'b1;
          end
        end
      end
      ST_SIFT_UP: begin
        w_state_nxt = ST_IDLE;
        if ((r_cursor != '0) && (r_heap[w_cur_par] > r_heap[r_cursor])) begin
          w_wr_a    = 1'b1;
          w_a_idx   = r_cursor;
          w_a_data  = r_heap[w_cur_par];
          w_wr_b    = 1'b1;
          w_b_idx   = w_cur_par;
          w_b_data  = r_heap[r_cursor];
          w_cur_ld  = 1'b1;
          w_cur_nxt = w_cur_par;
          if (w_cur_par != '0) w_state_nxt = ST_SIFT_UP;
        end
      end
      ST_SIFT_DOWN: begin
        w_state_nxt = ST_IDLE;
        if (w_mc_has && (w_mc_key < r_heap[r_cursor])) begin
          w_wr_a    = 1'b1;
          w_a_idx   = r_cursor;
          w_a_data  = w_mc_key;
          w_wr_b    = 1'b1;
          w_b_idx   = w_mc_idx;
          w_b_data  = r_heap[r_cursor];
          w_cur_ld  = 1'b1;
          w_cur_nxt = w_mc_idx;
          if (w_mc_deeper) w_state_nxt = ST_SIFT_DOWN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_cnt_inc) w_cnt_nxt = r_count + CNT_W'(1);
    if (w_cnt_dec) w_cnt_nxt = r_count - CNT_W'(1);
  end

  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      for (int i = 0; i < DEPTH; i++) r_heap[i] <= '0;
      r_count  <= '0;
      r_cursor <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      if (w_wr_a) r_heap[w_a_idx] <= w_a_data;
      if (w_wr_b) r_heap[w_b_idx] <= w_b_data;
      if (w_cur_ld) r_cursor <= w_cur_nxt;
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == FULL_CNT);
      r_empty <= (w_cnt_nxt == '0);
      r_err   <= w_reject;
    end
  end

  assign q.cmd_ready = (r_state == ST_IDLE);
  assign q.top_valid = !r_empty && (r_state == ST_IDLE);
  assign q.top_data  = r_heap[0];
  assign q.count     = r_count;
  assign q.full      = r_full;
  assign q.empty     = r_empty;
  assign q.err       = r_err;

endmodule

// File: tb/tb_heapq_moore.sv
// tb/tb_heapq_moore.sv - directed bench for heapq_moore (DEPTH 8 and DEPTH 16 instances)
module tb_heapq_moore;
  import heapq_pkg::*;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  heapq_moore_if #(.DATA_W(32), .CNT_W(4)) if8 ();
  heapq_moore_if #(.DATA_W(32), .CNT_W(5)) if16 ();

  heapq_moore #(.DATA_W(32), .DEPTH(8)) u_dut8 (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .q               (if8)
  );

  heapq_moore #(.DATA_W(32), .DEPTH(16)) u_dut16 (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .q               (if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send8(input logic [1:0] op, input logic [31:0] data);
    @(negedge clk);
    if8.cmd_valid = 1'b1;
    if8.cmd_op    = op;
    if8.cmd_data  = data;
    @(negedge clk);
    if8.cmd_valid = 1'b0;
  endtask

  task automatic send16(input logic [1:0] op, input logic [31:0] data);
    @(negedge clk);
    if16.cmd_valid = 1'b1;
    if16.cmd_op    = op;
    if16.cmd_data  = data;
    @(negedge clk);
    if16.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle8(input string tag);
    int n = 0;
    while (!if8.cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, if8.cmd_ready, 1'b1);
  endtask

  task automatic wait_idle16(input string tag);
    int n = 0;
    while (!if16.cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, if16.cmd_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] exp_pop [3];
    n_checks = 0;
    n_fail   = 0;
    rstn = 1'b0;
    if8.cmd_valid  = 1'b0; if8.cmd_op  = OP_NOP; if8.cmd_data  = '0;
    if16.cmd_valid = 1'b0; if16.cmd_op = OP_NOP; if16.cmd_data = '0;
    repeat (3) @(negedge clk);

    chk("rst_count",     if8.count,     4'd0);
    chk("rst_empty",     if8.empty,     1'b1);
    chk("rst_full",      if8.full,      1'b0);
    chk("rst_top_valid", if8.top_valid, 1'b0);
    chk("rst_top_data",  if8.top_data,  32'd0);
    chk("rst_ready",     if8.cmd_ready, 1'b1);
    chk("rst_err",       if8.err,       1'b0);
    rstn = 1'b1;

    // Push 5,3,9,1,7: 9 and 7 land without a sift, 1 needs two levels
    send8(OP_PUSH, 5);  wait_idle8("idle_p5"); chk("top_p5", if8.top_data, 5);
    send8(OP_PUSH, 3);  wait_idle8("idle_p3"); chk("top_p3", if8.top_data, 3);
    send8(OP_PUSH, 9);  chk("ready_nosift_p9", if8.cmd_ready, 1'b1);
    chk("top_p9", if8.top_data, 3);
    send8(OP_PUSH, 1);  chk("ready_sift_p1", if8.cmd_ready, 1'b0);
    chk("tv_sift_p1", if8.top_valid, 1'b0);
    wait_idle8("idle_p1"); chk("top_p1", if8.top_data, 1);
    send8(OP_PUSH, 7);  wait_idle8("idle_p7"); chk("top_p7", if8.top_data, 1);
    chk("count5", if8.count, 4'd5);
    chk("tv5", if8.top_valid, 1'b1);

    chk("pop_top0", if8.top_data, 1); send8(OP_POP, 0); wait_idle8("idle_pop0");
    chk("pop_top1", if8.top_data, 3); send8(OP_POP, 0); wait_idle8("idle_pop1");
    chk("pop_top2", if8.top_data, 5); send8(OP_POP, 0); wait_idle8("idle_pop2");
    chk("pop_top3", if8.top_data, 7); send8(OP_POP, 0); wait_idle8("idle_pop3");
    chk("pop_top4", if8.top_data, 9); send8(OP_POP, 0); wait_idle8("idle_pop4");
    chk("pop_empty", if8.empty, 1'b1);
    chk("pop_count", if8.count, 4'd0);
    chk("pop_tv",    if8.top_valid, 1'b0);

    // Fill with 8..1, then overflow
    for (int k = 8; k >= 1; k--) begin
      send8(OP_PUSH, 32'(k));
      wait_idle8("idle_fill");
    end
    chk("fill_full",  if8.full,     1'b1);
    chk("fill_count", if8.count,    4'd8);
    chk("fill_top",   if8.top_data, 1);
    send8(OP_PUSH, 0);
    chk("ovf_err",   if8.err,      1'b1);
    chk("ovf_count", if8.count,    4'd8);
    chk("ovf_top",   if8.top_data, 1);
    @(negedge clk);
    chk("ovf_err_pulse", if8.err, 1'b0);

    for (int k = 1; k <= 8; k++) begin
      chk("drain_top", if8.top_data, 32'(k));
      send8(OP_POP, 0);
      wait_idle8("idle_drain");
    end
    send8(OP_POP, 0);
    chk("udf_err",   if8.err,   1'b1);
    chk("udf_count", if8.count, 4'd0);
    chk("udf_empty", if8.empty, 1'b1);

    // REPLACE on {2,4,6}
    send8(OP_PUSH, 2); wait_idle8("idle_r2");
    send8(OP_PUSH, 4); wait_idle8("idle_r4");
    send8(OP_PUSH, 6); wait_idle8("idle_r6");
    send8(OP_REPLACE, 5);
`ifdef HEAPQ_REPLACE_EN
    chk("repl_err", if8.err, 1'b0);
    wait_idle8("idle_repl");
    chk("repl_top", if8.top_data, 4);
    exp_pop = '{32'd4, 32'd5, 32'd6};
`else
    chk("repl_err", if8.err, 1'b1);
    wait_idle8("idle_repl");
    chk("repl_top", if8.top_data, 2);
    exp_pop = '{32'd2, 32'd4, 32'd6};
`endif
    chk("repl_count", if8.count, 4'd3);
    for (int k = 0; k < 3; k++) begin
      chk("repl_drain", if8.top_data, exp_pop[k]);
      send8(OP_POP, 0);
      wait_idle8("idle_repl_drain");
    end
    chk("repl_empty", if8.empty, 1'b1);

    // Equal keys never sift
    for (int k = 0; k < 8; k++) begin
      send8(OP_PUSH, 32'hA);
      chk("eq_ready", if8.cmd_ready, 1'b1);
      chk("eq_top",   if8.top_data,  32'hA);
    end
    chk("eq_full", if8.full, 1'b1);

    // DEPTH 16: ascending fill, then a pop starts a multi-level sift-down
    for (int k = 1; k <= 16; k++) begin
      send16(OP_PUSH, 32'(k));
      wait_idle16("idle16_fill");
    end
    chk("d16_count", if16.count, 5'd16);
    chk("d16_full",  if16.full,  1'b1);
    send16(OP_POP, 0);
    chk("d16_sifting", if16.cmd_ready, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    chk("d16_rst_count", if16.count,     5'd0);
    chk("d16_rst_empty", if16.empty,     1'b1);
    chk("d16_rst_ready", if16.cmd_ready, 1'b1);
    chk("d16_rst_tv",    if16.top_valid, 1'b0);
    chk("d16_rst_top",   if16.top_data,  32'd0);
    rstn = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
